rr_arbiter_fsm: RTL and testbench

Round-robin arbiter that shares one downstream FSM/datapath resource between N requesters. It is a three-state Moore controller: IDLE, GRANT, RELEASE. It grants one requester at a time and holds the grant until that requester signals done, withdraws its request, or exceeds a hold limit. It sits between the requesting blocks and the shared resource and drives the resource's select/enable.

---
 rtl/rr_arbiter_fsm.sv | 126 ++++++++++++
 tb/tb_rr_arbiter_fsm.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_fsm.sv
// rr_arbiter_fsm: round-robin Moore arbiter (IDLE/GRANT/RELEASE) sharing one
// resource among N requesters; ports: clk, reset(n), req, done, grant, gnt_id, busy, timeout.
module rr_arbiter_fsm #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_REL   = 2'd2
  } state_t;

  localparam int HW = 8;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_d;
  logic [IDW-1:0] id_d;
  logic           busy_d;
  logic           tmo_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [IDW-1:0] last_q, last_d;

  logic           sel_vld;
  logic [IDW-1:0] sel_idx;
  logic           id_done;
  logic           id_req;
  logic           hit_max;
  logic           grant_exit;

  // Rotating search, starting just past the last served requester.
  always_comb begin : pick
    int idx;
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(last_q) + 1 + i) % N;
      if (!sel_vld && req[idx[IDW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = idx[IDW-1:0];
      end
    end
  end

  assign id_done    = done[gnt_id];
  assign id_req     = req[gnt_id];
  assign hit_max    = (hold_q == HW'(MAX_HOLD));
  assign grant_exit = id_done | ~id_req | hit_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant   <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      hold_q  <= '0;
      last_q  <= IDW'(N - 1);
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      gnt_id  <= id_d;
      busy    <= busy_d;
      timeout <= tmo_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = sel_vld ? S_GRANT : S_IDLE;
      S_GRANT: state_d = grant_exit ? S_REL : S_GRANT;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    id_d    = gnt_id;
    busy_d  = 1'b0;
    tmo_d   = 1'b0;
    hold_d  = '0;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          grant_d[sel_idx] = 1'b1;
          id_d             = sel_idx;
          busy_d           = 1'b1;
          hold_d           = HW'(1);
        end
      end
      S_GRANT: begin
        if (grant_exit) begin
          // done wins over the hold limit
          tmo_d = hit_max & ~id_done & id_req;
        end else begin
          grant_d = grant;
          busy_d  = 1'b1;
          hold_d  = hit_max ? hold_q : hold_q + HW'(1);
        end
      end
      S_REL: begin
        last_d = gnt_id;
      end
      default: begin
        id_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// tb_rr_arbiter_fsm: directed bench for rr_arbiter_fsm (N=4, MAX_HOLD=8)
// drives req/done/reset and checks grant, gnt_id, busy, timeout.
module tb_rr_arbiter_fsm;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int checks;
  int errors;

  rr_arbiter_fsm #(
    .N(4),
    .IDW(2),
    .MAX_HOLD(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .done(done),
    .grant(grant),
    .gnt_id(gnt_id),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_g(input string tag, input logic [3:0] g,
                       input logic [1:0] id, input logic b,
                       input logic t);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".tmo"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    int seq [6];
    checks = 0;
    errors = 0;
    seq = '{0, 1, 2, 3, 0, 1};

    // reset held with all requests pending
    reset = 1'b0;
    req   = 4'b1111;
    done  = 4'b0000;
    step();
    step();
    step();
    chk_g("rst", 4'b0000, 2'd0, 1'b0, 1'b0);

    // basic grant: 0 first, then 2
    req = 4'b0101;
    reset = 1'b1;
    #3;
    chk("rst_rel_nogrant", 32'(grant), 32'h0);
    @(posedge clk);
    #1;
    chk_g("g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    step();
    chk("g0_hold", 32'(grant), 32'h1);
    done = 4'b0001;
    step();
    done = 4'b0000;
    chk_g("g0_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_g("g0_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_g("g2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // req of grantee dropped mid-grant
    req = 4'b1000;
    step();
    chk_g("g2_drop", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    step();
    chk_g("g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 4'b1000;
    req  = 4'b1111;
    step();
    done = 4'b0000;
    chk("g3_rel", 32'(grant), 32'h0);
    step();

    // fairness with all requesting
    for (int k = 0; k < 6; k++) begin
      step();
      chk_g($sformatf("fair%0d", k), 4'(1 << seq[k]), 2'(seq[k]),
            1'b1, 1'b0);
      step();
      chk($sformatf("fair%0d_c2", k), 32'(grant), 32'(1 << seq[k]));
      done = 4'(1 << seq[k]);
      step();
      done = 4'b0000;
      chk($sformatf("fair%0d_d1", k), 32'(grant), 32'h0);
      step();
      chk($sformatf("fair%0d_d2", k), 32'(grant), 32'h0);
    end

    // hold limit on a lone requester
    req = 4'b0100;
    step();
    chk_g("to_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk($sformatf("to_c%0d", i), 32'(grant), 32'h4);
    end
    step();
    chk_g("to_rel", 4'b0000, 2'd2, 1'b0, 1'b1);
    step();
    chk_g("to_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    chk_g("to_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // done on the MAX_HOLD cycle: no timeout
    for (int i = 2; i <= 8; i++) step();
    chk("mh_c8", 32'(grant), 32'h4);
    done = 4'b0100;
    step();
    done = 4'b0000;
    chk_g("mh_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b0011;
    step();
    step();
    chk_g("g0b", 4'b0001, 2'd0, 1'b1, 1'b0);

    // foreign done ignored
    done = 4'b0010;
    step();
    done = 4'b0000;
    chk_g("foreign_done", 4'b0001, 2'd0, 1'b1, 1'b0);

    // reset while requester 1 is granted
    req = 4'b0010;
    step();
    step();
    step();
    chk_g("g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    reset = 1'b0;
    req   = 4'b0011;
    #2;
    chk_g("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("mid_rst_hold", 32'(grant), 32'h0);
    reset = 1'b1;
    step();
    chk_g("after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
